rom_reader: RTL and testbench

- Read-side initiator for the coefficient ROM (synchronous, 1-cycle read latency) in the convolution processor.
- On a start pulse, reads a contiguous run of KERNEL_LEN words beginning at a base address.
- Delivers the words as a valid/ready stream to the MAC datapath, absorbing ROM latency and downstream backpressure with a 2-entry skid buffer.

---
 rtl/rom_reader_pkg.sv | 16 +
 rtl/rom_reader_skid.sv | 56 +++++
 rtl/rom_reader.sv | 119 +++++++++++
 tb/tb_rom_reader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_reader_pkg.sv
// Shared definitions for the coefficient ROM path: default geometry and the
// reader's state encoding, also used by the ROM and the MAC controller.
package rom_reader_pkg;

    localparam int ROM_ADDR_W     = 6;
    localparam int ROM_DATA_W     = 8;
    localparam int ROM_KERNEL_LEN = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rr_state_t;

endpackage

// File: rtl/rom_reader_skid.sv
// Two-entry FIFO that absorbs ROM read latency against output backpressure.
// Push and pop may coincide at any occupancy; slot0 is always the head.
module rom_reader_skid #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] slot0;
    logic [DATA_W-1:0] slot1;
    logic              do_pop;

    assign do_pop = pop && (count != 2'd0);
    assign dout   = slot0;
    assign empty  = (count == 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= din;
                    else               slot1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= din;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !do_pop && count == 2'd2));

endmodule

// File: rtl/rom_reader.sv
// Reads KERNEL_LEN consecutive coefficient words from the synchronous ROM
// starting at base_addr and streams them to the MAC datapath.
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int ADDR_W     = ROM_ADDR_W,
    parameter int DATA_W     = ROM_DATA_W,
    parameter int KERNEL_LEN = ROM_KERNEL_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int              CNT_W = $clog2(KERNEL_LEN + 1);
    localparam logic [CNT_W-1:0] LEN  = CNT_W'(KERNEL_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(KERNEL_LEN - 1);

    rr_state_t         state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic              inflight;
    logic              skid_empty;
    logic [1:0]        skid_count;
    logic [DATA_W-1:0] skid_head;
    logic              push;
    logic              pop;
    logic              hs;

    // A read is issued only while buffered plus returning words stay below two.
    assign rom_en   = (state == FETCH) && (issue_cnt < LEN) &&
                      (({1'b0, skid_count} + {2'b00, inflight}) < 3'd2);
    assign rom_addr = rom_en ? rd_ptr : addr_q;

    // Output stream: a word transfers on any cycle where out_valid and
    // out_ready are both high; out_valid/out_data never change while stalled.
    // A word returning from the ROM into an empty buffer is presented the
    // same cycle and is only stored if the consumer does not take it.
    assign out_valid = !skid_empty || inflight;
    assign out_data  = !skid_empty ? skid_head : (inflight ? rom_data : '0);
    assign out_last  = out_valid && (out_cnt == LAST);
    assign hs        = out_valid && out_ready;
    assign pop       = !skid_empty && out_ready;
    assign push      = inflight && !(skid_empty && out_ready);

    rom_reader_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (rom_data),
        .dout  (skid_head),
        .empty (skid_empty),
        .count (skid_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            addr_q    <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
            inflight  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            inflight <= rom_en;
            done     <= 1'b0;
            if (rom_en) begin
                addr_q    <= rd_ptr;
                rd_ptr    <= rd_ptr + ADDR_W'(1);
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (hs) out_cnt <= out_cnt + CNT_W'(1);

            case (state)
                IDLE: begin
                    if (start) begin
                        rd_ptr    <= base_addr;
                        issue_cnt <= '0;
                        out_cnt   <= '0;
                        busy      <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (rom_en && issue_cnt == LAST) state <= DRAIN;
                end
                DRAIN: begin
                    if (hs && out_cnt == LAST) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_reader.sv
// Bench for rom_reader: three instances (run lengths 9, 4 and 1) each with a
// behavioural 1-cycle ROM; a per-run expected queue holds the words to stream.
module tb_rom_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_v [3];
    logic [5:0] base_v  [3];
    logic       ready_v [3];
    logic [7:0] rdata_v [3];
    wire        busy_v  [3];
    wire        done_v  [3];
    wire        en_v    [3];
    wire        valid_v [3];
    wire        last_v  [3];
    wire  [5:0] addr_v  [3];
    wire  [7:0] data_v  [3];

    logic [7:0] rom_mem [64];
    int total;
    int bad;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int u = 0; u < 3; u++)
            if (en_v[u]) rdata_v[u] <= rom_mem[addr_v[u]];
    end

    rom_reader #(.ADDR_W(6), .DATA_W(8), .KERNEL_LEN(9)) dut9 (
        .clk(clk), .rst(rst), .start(start_v[0]), .base_addr(base_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .rom_addr(addr_v[0]), .rom_en(en_v[0]),
        .rom_data(rdata_v[0]), .out_data(data_v[0]), .out_valid(valid_v[0]),
        .out_ready(ready_v[0]), .out_last(last_v[0]));

    rom_reader #(.ADDR_W(6), .DATA_W(8), .KERNEL_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_v[1]), .base_addr(base_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .rom_addr(addr_v[1]), .rom_en(en_v[1]),
        .rom_data(rdata_v[1]), .out_data(data_v[1]), .out_valid(valid_v[1]),
        .out_ready(ready_v[1]), .out_last(last_v[1]));

    rom_reader #(.ADDR_W(6), .DATA_W(8), .KERNEL_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[2]), .base_addr(base_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .rom_addr(addr_v[2]), .rom_en(en_v[2]),
        .rom_data(rdata_v[2]), .out_data(data_v[2]), .out_valid(valid_v[2]),
        .out_ready(ready_v[2]), .out_last(last_v[2]));

    // mode 0: ready high; 1: random ready; 2: ready low 5 cycles from first word;
    // 3: ready high plus a second start at cycle 4. Cycle 1 is the cycle after start.
    task automatic run_case(input int u, input int k, input logic [5:0] b, input int mode,
                            input string name, output int first_val, output int last_val,
                            output int done_cyc);
        logic [7:0] exp_q[$];
        logic [7:0] exp_w;
        logic [7:0] held_d;
        logic       held_v;
        logic       rdy;
        int nword;
        int ndone;
        int issued;
        for (int i = 0; i < k; i++) exp_q.push_back(rom_mem[(int'(b) + i) % 64]);
        nword = 0; ndone = 0; issued = 0; held_v = 1'b0; held_d = '0;
        first_val = -1; last_val = -1; done_cyc = -1;
        base_v[u] = b; start_v[u] = 1'b1;
        @(posedge clk); #1;
        base_v[u] = ~b;
        for (int cyc = 1; cyc < 400; cyc++) begin
            start_v[u] = (mode == 3 && cyc == 4);
            if (valid_v[u] && first_val < 0) first_val = cyc;
            case (mode)
                1:       rdy = 1'($urandom_range(0, 1));
                2:       rdy = !(first_val >= 0 && cyc < first_val + 5);
                default: rdy = 1'b1;
            endcase
            ready_v[u] = rdy;

            total++;
            if (busy_v[u] !== (done_cyc < 0)) begin
                bad++;
                $display("FAIL %s busy cyc=%0d got=%b want=%b", name, cyc, busy_v[u], done_cyc < 0);
            end
            if (en_v[u]) begin
                total++;
                if (issued >= k || addr_v[u] !== 6'((int'(b) + issued) % 64) ||
                    (mode == 0 && cyc != issued + 1)) begin
                    bad++;
                    $display("FAIL %s rom_addr cyc=%0d got=%0d want=%0d read#%0d", name, cyc,
                             addr_v[u], (int'(b) + issued) % 64, issued);
                end
                issued++;
                total++;
                if (issued - nword > 2) begin
                    bad++;
                    $display("FAIL %s outstanding cyc=%0d got=%0d want<=2", name, cyc, issued - nword);
                end
            end
            if (held_v) begin
                total++;
                if (valid_v[u] !== 1'b1 || data_v[u] !== held_d) begin
                    bad++;
                    $display("FAIL %s stall_hold cyc=%0d got=%b/%h want=1/%h", name, cyc,
                             valid_v[u], data_v[u], held_d);
                end
            end
            held_v = 1'b0;
            total++;
            if (last_v[u] !== (valid_v[u] && nword == k - 1)) begin
                bad++;
                $display("FAIL %s out_last cyc=%0d got=%b word#%0d", name, cyc, last_v[u], nword);
            end
            if (valid_v[u]) begin
                last_val = cyc;
                if (rdy) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL %s extra_word cyc=%0d got=%h want=none", name, cyc, data_v[u]);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (data_v[u] !== exp_w || (mode == 0 && cyc != nword + 2)) begin
                            bad++;
                            $display("FAIL %s out_data cyc=%0d got=%h want=%h word#%0d", name, cyc,
                                     data_v[u], exp_w, nword);
                        end
                    end
                    nword++;
                end else begin
                    held_v = 1'b1;
                    held_d = data_v[u];
                end
            end
            if (done_v[u]) begin
                ndone++;
                total++;
                if (nword != k || done_cyc >= 0) begin
                    bad++;
                    $display("FAIL %s done cyc=%0d words=%0d want=%0d dones=%0d", name, cyc, nword, k, ndone);
                end
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc > done_cyc) break;
            @(posedge clk); #1;
        end
        start_v[u] = 1'b0;
        ready_v[u] = 1'b1;
        total++;
        if (done_cyc < 0 || ndone != 1 || nword != k || issued != k || exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s run_end got done=%0d words=%0d reads=%0d left=%0d want 1/%0d/%0d/0",
                     name, ndone, nword, issued, exp_q.size(), k, k);
        end
    endtask

    task automatic test_reset;
        for (int u = 0; u < 3; u++) begin
            total++;
            if ({busy_v[u], done_v[u], en_v[u], addr_v[u], valid_v[u], last_v[u], data_v[u]} !== 19'd0) begin
                bad++;
                $display("FAIL reset_outputs dut%0d got busy=%b done=%b en=%b addr=%h v=%b l=%b d=%h want all 0",
                         u, busy_v[u], done_v[u], en_v[u], addr_v[u], valid_v[u], last_v[u], data_v[u]);
            end
        end
    endtask

    task automatic test_basic;
        int f, l, d;
        run_case(0, 9, 6'd0, 0, "basic", f, l, d);
        total++;
        if (f != 2 || l != 10 || d != 11) begin
            bad++;
            $display("FAIL basic_latency got first=%0d last=%0d done=%0d want 2/10/11", f, l, d);
        end
    endtask

    task automatic test_wrap;
        int f, l, d;
        run_case(1, 4, 6'd62, 0, "wrap", f, l, d);
        total++;
        if (f != 2 || l != 5 || d != 6) begin
            bad++;
            $display("FAIL wrap_latency got first=%0d last=%0d done=%0d want 2/5/6", f, l, d);
        end
    endtask

    task automatic test_stall;
        int f, l, d;
        run_case(0, 9, 6'd0, 2, "stall", f, l, d);
        total++;
        if (f != 2 || d <= 11) begin
            bad++;
            $display("FAIL stall_timing got first=%0d done=%0d want 2/>11", f, d);
        end
    endtask

    task automatic test_restart_ignored;
        int f, l, d;
        run_case(0, 9, 6'($urandom_range(0, 63)), 3, "restart", f, l, d);
        total++;
        if (d != 11) begin
            bad++;
            $display("FAIL restart_done got=%0d want=11", d);
        end
    endtask

    task automatic test_len1;
        int f, l, d;
        run_case(2, 1, 6'($urandom_range(0, 63)), 0, "len1", f, l, d);
        total++;
        if (f != 2 || l != 2 || d != 3) begin
            bad++;
            $display("FAIL len1_latency got first=%0d last=%0d done=%0d want 2/2/3", f, l, d);
        end
    endtask

    task automatic test_mid_reset;
        int f, l, d;
        base_v[0] = 6'd3; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        total++;
        if (busy_v[0] !== 1'b1 || en_v[0] !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset got busy=%b en=%b want 1/1", busy_v[0], en_v[0]);
        end
        #2 rst = 1'b1;
        #1;
        test_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_case(0, 9, 6'd40, 0, "after_reset", f, l, d);
        total++;
        if (d != 11) begin
            bad++;
            $display("FAIL after_reset_done got=%0d want=11", d);
        end
    endtask

    task automatic test_random;
        int f, l, d;
        for (int i = 0; i < 64; i++) rom_mem[i] = 8'($urandom);
        for (int r = 0; r < 100; r++)
            run_case(0, 9, 6'($urandom_range(0, 63)), 1, "random", f, l, d);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int u = 0; u < 3; u++) begin
            start_v[u] = 1'b0;
            base_v[u]  = 6'd0;
            ready_v[u] = 1'b1;
            rdata_v[u] = 8'd0;
        end
        for (int i = 0; i < 64; i++) rom_mem[i] = 8'(i + 16);
        #2;
        test_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        test_basic();
        test_wrap();
        test_stall();
        test_restart_ignored();
        test_len1();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
